even_sample_fifo: RTL and testbench



---
 rtl/even_sample_fifo_pkg.sv | 17 +
 rtl/even_sample_fifo_sync_fifo_core.sv | 72 +++++++
 rtl/even_sample_fifo.sv | 93 +++++++++
 tb/tb_even_sample_fifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/even_sample_fifo_pkg.sv
// Shared types and default sizing for the even-sample FIFO slice.
package even_sample_fifo_pkg;

    localparam int SAMPLE_W   = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

    typedef logic [SAMPLE_W-1:0] sample_t;

    // A sample is even when it is valid and its LSB is clear.
    function automatic logic is_even(input logic valid, input logic lsb);
        return valid & ~lsb;
    endfunction

endpackage

// File: rtl/even_sample_fifo_sync_fifo_core.sv
// Synchronous FIFO core: storage array, wrap-bit pointers, full/empty/level.
module sync_fifo_core
    import even_sample_fifo_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic             full_s;
    logic             empty_s;

    // Storage array: written at the tail on push, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Status decode from the registered pointers.
    always_comb begin
        full_s  = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        empty_s = (wr_ptr_r == rd_ptr_r);
    end

    assign full    = full_s;
    assign empty   = empty_s;
    assign level   = wr_ptr_r - rd_ptr_r;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/even_sample_fifo.sv
// Even-value filter on a counter stream with a holding register, FIFO
// buffering toward a valid/ready consumer, and overflow accounting.
module even_sample_fifo
    import even_sample_fifo_pkg::*;
#(
    parameter int WIDTH  = SAMPLE_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int DROP_W = CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic [WIDTH-1:0]       last_even,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam logic [DROP_W-1:0] DROP_SAT = {DROP_W{1'b1}};

    logic               even_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;
    logic               full_s;
    logic               empty_s;
    logic [WIDTH-1:0]   last_even_r;
    logic               overflow_r;
    logic [DROP_W-1:0]  drop_cnt_r;

    // Handshake decode: a pop frees a slot in the same cycle, so a full
    // FIFO with a pop still accepts the incoming even sample.
    always_comb begin
        even_s = is_even(in_valid, in_data[0]);
        pop_s  = ~empty_s & out_ready;
        push_s = even_s & (~full_s | pop_s);
        drop_s = even_s & full_s & ~pop_s;
    end

    sync_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (in_data),
        .rd_data (out_data),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level)
    );

    // Holding register: captures every even sample, accepted or dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_even_r <= {WIDTH{1'b0}};
        end else if (even_s) begin
            last_even_r <= in_data;
        end else begin
            last_even_r <= last_even_r;
        end
    end

    // Drop accounting: sticky flag plus saturating counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (drop_cnt_r != DROP_SAT) begin
                drop_cnt_r <= drop_cnt_r + {{(DROP_W-1){1'b0}}, 1'b1};
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign last_even = last_even_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;
    assign out_valid = ~empty_s;

endmodule

// File: tb/tb_even_sample_fifo.sv
// Scoreboard bench for even_sample_fifo: stimulus queues expected FIFO
// outputs, a negedge monitor pops and compares on each handshake.
module tb_even_sample_fifo;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic [WIDTH-1:0]  last_even;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [LW-1:0]     level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    logic [WIDTH-1:0]  exp_q [$];
    int                stim_cmp;
    int                stim_err;
    int                mon_cmp;
    int                mon_err;

    even_sample_fifo #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .last_even (last_even),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_cmp = mon_cmp + 1;
            if (exp_q.size() == 0) begin
                mon_err = mon_err + 1;
                $display("FAIL out_data_unexpected: got 0x%08h, required no output", out_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    mon_err = mon_err + 1;
                    $display("FAIL out_data_stream: got 0x%08h, required 0x%08h", out_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] req);
        stim_cmp = stim_cmp + 1;
        if (act !== req) begin
            stim_err = stim_err + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs; returns #1 after the edge that sampled them.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic rdy);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_cmp = 0; stim_err = 0; mon_cmp = 0; mon_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        step(1'b0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 1'b0);
        check("rst_last_even", last_even, 32'd0);
        check("rst_out_data",  out_data,  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_level",     {29'd0, level}, 32'd0);
        check("rst_overflow",  {31'd0, overflow}, 32'd0);
        check("rst_drop_cnt",  {24'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;

        // 1: counter 0..9 with consumer always ready
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) exp_q.push_back(i);
            step(1'b1, i, 1'b1);
            check("t1_last_even", last_even, (i % 2 == 0) ? i : i - 1);
        end
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        check("t1_overflow", {31'd0, overflow}, 32'd0);
        check("t1_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        check("t1_level",    {29'd0, level}, 32'd0);

        // 2: stalled consumer, six evens into four slots
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(2 * i);
            step(1'b1, 2 * i, 1'b0);
        end
        check("t2_level",     {29'd0, level}, 32'd4);
        check("t2_overflow",  {31'd0, overflow}, 32'd1);
        check("t2_drop_cnt",  {24'd0, drop_cnt}, 32'd2);
        check("t2_last_even", last_even, 32'd10);
        check("t2_head_hold", out_data, 32'd0);

        // 3: full FIFO, push 12 and pop together
        exp_q.push_back(32'd12);
        step(1'b1, 32'd12, 1'b1);
        check("t3_level",    {29'd0, level}, 32'd4);
        check("t3_drop_cnt", {24'd0, drop_cnt}, 32'd2);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1);
        check("t3_drained",  {29'd0, level}, 32'd0);

        // 4: odd values only
        for (int i = 1; i < 16; i += 2) step(1'b1, i, 1'b1);
        check("t4_level",     {29'd0, level}, 32'd0);
        check("t4_out_valid", {31'd0, out_valid}, 32'd0);
        check("t4_last_even", last_even, 32'd12);
        check("t4_drop_cnt",  {24'd0, drop_cnt}, 32'd2);

        // 5: reset mid-stream with three entries held
        for (int i = 0; i < 3; i++) step(1'b1, 20 + 2 * i, 1'b0);
        check("t5_level_pre", {29'd0, level}, 32'd3);
        rst_n = 1'b0;
        exp_q.delete();
        step(1'b1, 32'd26, 1'b1);
        check("t5_last_even", last_even, 32'd0);
        check("t5_out_data",  out_data,  32'd0);
        check("t5_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_level",     {29'd0, level}, 32'd0);
        check("t5_overflow",  {31'd0, overflow}, 32'd0);
        check("t5_drop_cnt",  {24'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        exp_q.push_back(32'd28);
        step(1'b1, 32'd28, 1'b1);
        check("t5_lat_valid", {31'd0, out_valid}, 32'd1);
        check("t5_lat_data",  out_data, 32'd28);
        step(1'b0, 32'd0, 1'b1);

        // 6: counter wrap, then 2*DEPTH+1 back-to-back pushes
        exp_q.push_back(32'hFFFF_FFFE);
        step(1'b1, 32'hFFFF_FFFE, 1'b1);
        exp_q.push_back(32'h0000_0000);
        step(1'b1, 32'h0000_0000, 1'b1);
        check("t6_last_even", last_even, 32'd0);
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            exp_q.push_back(32'h100 + 2 * i);
            step(1'b1, 32'h100 + 2 * i, 1'b1);
            check("t6_valid_hold", {31'd0, out_valid}, 32'd1);
        end

        // Bounded drain of anything still expected
        begin
            int budget;
            budget = 0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            while (exp_q.size() != 0 && budget < 20) begin
                @(posedge clk);
                #1;
                budget++;
            end
            check("final_queue_empty", exp_q.size(), 32'd0);
            check("final_level", {29'd0, level}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 stim_cmp + mon_cmp, stim_err + mon_err);
        $finish;
    end

endmodule
